// File: rtl/dcp_pkg.sv
// Shared constants for the debug control panel print path: FSM states, request types, ASCII codes.
// Pure declarations; no latency or backpressure of its own.
package dcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic TX_CHAR = 1'b0;
    localparam logic TX_HEX  = 1'b1;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_SP = 8'h20;

endpackage

// File: rtl/dcp_print_if.sv
// Request/acknowledge plus valid/ready byte bus between the panel FSM, the formatter and the UART.
// Requester holds req_tx until ack_tx; byte sink throttles the formatter through rdy_tx.
interface dcp_print_if;

    logic        req_tx;
    logic        type_tx;
    logic [31:0] dout_tx;
    logic        ack_tx;
    logic [7:0]  d_tx;
    logic        vld_tx;
    logic        rdy_tx;

    // Master: the requester, which also stands in for the byte sink.
    modport master (
        output req_tx,
        output type_tx,
        output dout_tx,
        output rdy_tx,
        input  ack_tx,
        input  d_tx,
        input  vld_tx
    );

    modport slave (
        input  req_tx,
        input  type_tx,
        input  dout_tx,
        input  rdy_tx,
        output ack_tx,
        output d_tx,
        output vld_tx
    );

endinterface

// File: rtl/dcp_print_nibble_to_ascii.sv
// Maps a 4-bit value to its uppercase ASCII hex digit; purely combinational, zero latency.
// No handshake; also shared with the receive-side parser's inverse check.
import dcp_pkg::*;

module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = '0;
        if (nibble < 4'd10)
            ascii = ASCII_0 + {4'd0, nibble};
        else
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
    end

endmodule

// File: rtl/dcp_print.sv
// Formats one raw char or a HEX_DIGITS-digit hex word onto a valid/ready byte stream, then pulses ack_tx;
// first byte one cycle after the request, rdy_tx stalls hold the byte; DCP_PRINT_SEP_EN appends a space to hex words.
import dcp_pkg::*;

module dcp_print #(
    parameter int HEX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rstn,
    dcp_print_if.slave  bus
);

    localparam logic [2:0] LAST_DIGIT = 3'(HEX_DIGITS - 1);

    state_t      state;
    logic        cap_type;
    logic [31:0] cap_data;
    logic [2:0]  cnt;
    logic        vld_q;
    logic        ack_q;

    logic [2:0]  nib_idx;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;
    logic        last_byte;
    logic        out_sp;
    logic [7:0]  cur_byte;
    logic        xfer;

    // Most-significant digit first: digit k sits at nibble HEX_DIGITS-1-k.
    assign nib_idx = LAST_DIGIT - cnt;
    assign nibble  = cap_data[{nib_idx, 2'b00} +: 4];

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nibble),
        .ascii  (hex_char)
    );

`ifdef DCP_PRINT_SEP_EN
    logic sep_phase;
    assign last_byte = (cap_type == TX_CHAR) || sep_phase;
    assign out_sp    = sep_phase;
`else
    assign last_byte = (cap_type == TX_CHAR) || (cnt == LAST_DIGIT);
    assign out_sp    = 1'b0;
`endif

    assign xfer = vld_q && bus.rdy_tx;

    // The byte is derived only from captured state, so it cannot move while stalled.
    always_comb begin
        cur_byte = 8'h00;
        if (vld_q) begin
            if (cap_type == TX_CHAR)
                cur_byte = cap_data[7:0];
            else if (out_sp)
                cur_byte = ASCII_SP;
            else
                cur_byte = hex_char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cap_type <= TX_CHAR;
            cap_data <= '0;
            cnt      <= '0;
            vld_q    <= 1'b0;
            ack_q    <= 1'b0;
`ifdef DCP_PRINT_SEP_EN
            sep_phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.req_tx) begin
                        cap_type <= bus.type_tx;
                        cap_data <= bus.dout_tx;
                        cnt      <= '0;
                        vld_q    <= 1'b1;
                        state    <= SEND;
`ifdef DCP_PRINT_SEP_EN
                        sep_phase <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last_byte) begin
                            vld_q <= 1'b0;
                            ack_q <= 1'b1;
                            state <= ACK;
                        end else begin
`ifdef DCP_PRINT_SEP_EN
                            if (cnt == LAST_DIGIT)
                                sep_phase <= 1'b1;
                            else
`endif
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ACK: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    vld_q <= 1'b0;
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.d_tx   = cur_byte;
    assign bus.vld_tx = vld_q;
    assign bus.ack_tx = ack_q;

endmodule

// File: tb/tb_dcp_print.sv
// Directed bench for dcp_print: char, hex, stalls, capture isolation, mid-transfer reset, back-to-back.
module tb_dcp_print;

`ifdef DCP_PRINT_SEP_EN
    localparam int SEP = 1;
`else
    localparam int SEP = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcp_print_if bus();

    dcp_print #(.HEX_DIGITS(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] got_bytes[$];
    int         got_cyc[$];
    int         ack_cyc;
    int         n_ack;
    int         unstable;
    int         first_vld;

    function automatic logic [71:0] pack_bytes();
        logic [71:0] p = '0;
        foreach (got_bytes[i]) p = {p[63:0], got_bytes[i]};
        return p;
    endfunction

    function automatic int last_cyc();
        if (got_cyc.size() == 0) return -1;
        return got_cyc[got_cyc.size() - 1];
    endfunction

    // Runs one request and records accepted bytes, their cycles and ack timing (cycle 1 follows the sampling edge).
    task automatic do_xfer(input logic t, input logic [31:0] d, input bit stall_en, input bit mutate);
        int   stall_cnt = 0;
        logic prev_hold = 1'b0;
        logic [7:0] prev_d = 8'h00;
        got_bytes.delete();
        got_cyc.delete();
        ack_cyc = -1; n_ack = 0; unstable = 0; first_vld = -1;
        @(negedge clk);
        bus.req_tx = 1'b1; bus.type_tx = t; bus.dout_tx = d; bus.rdy_tx = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.req_tx = 1'b0;
            if (mutate && k == 2) begin
                bus.dout_tx = 32'h0;
                bus.type_tx = ~t;
            end
            if (stall_en && (got_bytes.size() % 2 == 1) && stall_cnt < 3) begin
                bus.rdy_tx = 1'b0;
                stall_cnt++;
            end else begin
                bus.rdy_tx = 1'b1;
            end
            #1;
            if (prev_hold && (bus.vld_tx !== 1'b1 || bus.d_tx !== prev_d)) unstable++;
            if (bus.vld_tx === 1'b1 && first_vld < 0) first_vld = k;
            if (bus.vld_tx === 1'b1 && bus.rdy_tx) begin
                got_bytes.push_back(bus.d_tx);
                got_cyc.push_back(k);
                stall_cnt = 0;
            end
            prev_hold = (bus.vld_tx === 1'b1) && !bus.rdy_tx;
            prev_d    = bus.d_tx;
            if (bus.ack_tx === 1'b1) begin
                n_ack++;
                ack_cyc = k;
            end
            if (ack_cyc >= 0 && k >= ack_cyc + 2) break;
        end
        bus.dout_tx = 32'h0; bus.type_tx = 1'b0; bus.rdy_tx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_chk++; if (bus.vld_tx !== 1'b0) $display("FAIL reset_vld got=%b exp=0", bus.vld_tx); else n_pass++;
        n_chk++; if (bus.ack_tx !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus.ack_tx); else n_pass++;
        n_chk++; if (bus.d_tx !== 8'h00) $display("FAIL reset_d got=%h exp=00", bus.d_tx); else n_pass++;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (bus.vld_tx !== 1'b0) $display("FAIL idle_vld got=%b exp=0", bus.vld_tx); else n_pass++;
    endtask

    task automatic test_char();
        do_xfer(1'b0, 32'h0000_0052, 1'b0, 1'b0);
        n_chk++; if (got_bytes.size() != 1) $display("FAIL char_count got=%0d exp=1", got_bytes.size()); else n_pass++;
        n_chk++; if (pack_bytes() !== 72'h52) $display("FAIL char_byte got=%h exp=52", pack_bytes()); else n_pass++;
        n_chk++; if (first_vld != 1) $display("FAIL char_vld_cycle got=%0d exp=1", first_vld); else n_pass++;
        n_chk++; if (ack_cyc != 2) $display("FAIL char_ack_cycle got=%0d exp=2", ack_cyc); else n_pass++;
        n_chk++; if (n_ack != 1) $display("FAIL char_ack_count got=%0d exp=1", n_ack); else n_pass++;
    endtask

    task automatic test_hex();
        logic [71:0] exp_p;
        exp_p = (SEP != 0) ? 72'h31_3233_3441_4243_4420 : 72'h00_3132_3334_4142_4344;
        do_xfer(1'b1, 32'h1234_ABCD, 1'b0, 1'b0);
        n_chk++; if (got_bytes.size() != 8 + SEP) $display("FAIL hex_count got=%0d exp=%0d", got_bytes.size(), 8 + SEP); else n_pass++;
        n_chk++; if (pack_bytes() !== exp_p) $display("FAIL hex_bytes got=%h exp=%h", pack_bytes(), exp_p); else n_pass++;
        n_chk++; if (first_vld != 1) $display("FAIL hex_vld_cycle got=%0d exp=1", first_vld); else n_pass++;
        n_chk++; if (last_cyc() != 8 + SEP) $display("FAIL hex_last_cycle got=%0d exp=%0d", last_cyc(), 8 + SEP); else n_pass++;
        n_chk++; if (ack_cyc != 9 + SEP) $display("FAIL hex_ack_cycle got=%0d exp=%0d", ack_cyc, 9 + SEP); else n_pass++;
        n_chk++; if (n_ack != 1) $display("FAIL hex_ack_count got=%0d exp=1", n_ack); else n_pass++;
    endtask

    task automatic test_stall();
        logic [71:0] exp_p;
        exp_p = (SEP != 0) ? 72'h30_3030_3030_3046_3020 : 72'h00_3030_3030_3030_4630;
        do_xfer(1'b1, 32'h0000_00F0, 1'b1, 1'b0);
        n_chk++; if (got_bytes.size() != 8 + SEP) $display("FAIL stall_count got=%0d exp=%0d", got_bytes.size(), 8 + SEP); else n_pass++;
        n_chk++; if (pack_bytes() !== exp_p) $display("FAIL stall_bytes got=%h exp=%h", pack_bytes(), exp_p); else n_pass++;
        n_chk++; if (unstable != 0) $display("FAIL stall_hold got=%0d unstable cycles exp=0", unstable); else n_pass++;
        n_chk++; if (ack_cyc != 21 + SEP) $display("FAIL stall_ack_cycle got=%0d exp=%0d", ack_cyc, 21 + SEP); else n_pass++;
        n_chk++; if (n_ack != 1) $display("FAIL stall_ack_count got=%0d exp=1", n_ack); else n_pass++;
    endtask

    task automatic test_capture();
        logic [71:0] exp_p;
        exp_p = (SEP != 0) ? 72'h44_4541_4442_4545_4620 : 72'h00_4445_4144_4245_4546;
        do_xfer(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        n_chk++; if (pack_bytes() !== exp_p) $display("FAIL capture_bytes got=%h exp=%h", pack_bytes(), exp_p); else n_pass++;
        n_chk++; if (n_ack != 1) $display("FAIL capture_ack_count got=%0d exp=1", n_ack); else n_pass++;
    endtask

    task automatic test_abort();
        int bad_ack = 0;
        int bad_vld = 0;
        @(negedge clk);
        bus.req_tx = 1'b1; bus.type_tx = 1'b1; bus.dout_tx = 32'h1234_ABCD; bus.rdy_tx = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.req_tx = 1'b0;
        end
        @(negedge clk); #1;
        n_chk++; if (bus.vld_tx !== 1'b1 || bus.d_tx !== 8'h34) $display("FAIL abort_inflight got vld=%b d=%h exp vld=1 d=34", bus.vld_tx, bus.d_tx); else n_pass++;
        rstn = 1'b0;
        @(negedge clk); #1;
        n_chk++; if (bus.vld_tx !== 1'b0) $display("FAIL abort_vld got=%b exp=0", bus.vld_tx); else n_pass++;
        n_chk++; if (bus.ack_tx !== 1'b0) $display("FAIL abort_ack got=%b exp=0", bus.ack_tx); else n_pass++;
        n_chk++; if (bus.d_tx !== 8'h00) $display("FAIL abort_d got=%h exp=00", bus.d_tx); else n_pass++;
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (bus.ack_tx !== 1'b0) bad_ack++;
            if (bus.vld_tx !== 1'b0) bad_vld++;
        end
        n_chk++; if (bad_ack != 0) $display("FAIL abort_no_ack got=%0d acks exp=0", bad_ack); else n_pass++;
        n_chk++; if (bad_vld != 0) $display("FAIL abort_no_vld got=%0d cycles exp=0", bad_vld); else n_pass++;
        do_xfer(1'b0, 32'h0000_0047, 1'b0, 1'b0);
        n_chk++; if (pack_bytes() !== 72'h47) $display("FAIL abort_fresh_byte got=%h exp=47", pack_bytes()); else n_pass++;
        n_chk++; if (ack_cyc != 2) $display("FAIL abort_fresh_ack got=%0d exp=2", ack_cyc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] vld_v = '0;
        logic [5:0] ack_v = '0;
        logic [7:0] d4 = 8'h00;
        @(negedge clk);
        bus.req_tx = 1'b1; bus.type_tx = 1'b0; bus.dout_tx = 32'h0000_0041; bus.rdy_tx = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            vld_v[k-1] = bus.vld_tx;
            ack_v[k-1] = bus.ack_tx;
            if (k == 4) begin
                d4 = bus.d_tx;
                bus.req_tx = 1'b0;
            end
        end
        n_chk++; if (vld_v !== 6'b001001) $display("FAIL b2b_vld got=%b exp=001001", vld_v); else n_pass++;
        n_chk++; if (ack_v !== 6'b010010) $display("FAIL b2b_ack got=%b exp=010010", ack_v); else n_pass++;
        n_chk++; if (d4 !== 8'h41) $display("FAIL b2b_byte got=%h exp=41", d4); else n_pass++;
    endtask

    initial begin
        bus.req_tx  = 1'b0;
        bus.type_tx = 1'b0;
        bus.dout_tx = 32'h0;
        bus.rdy_tx  = 1'b1;
        test_reset();
        test_char();
        test_hex();
        test_stall();
        test_capture();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
